// File: rtl/flash_sample_fetcher.sv
// flash_sample_fetcher
//   Reads 32-bit words from flash over an Avalon-MM read master, splits each
//   word into two 16-bit samples and presents one sample per sample period.
//   Supports pause, forward/backward playback, restart and address wrap.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   sample_freq_div      clk cycles per sample period (clamped to MIN_DIV)
//   pause                1 = hold playback (tick counter frozen)
//   forward              1 = ascending addresses / low half first
//   fetcher_reset        single-cycle restart request
//   flash_*              Avalon-MM read master (one outstanding read)
//   audio_sample         current sample, two's complement
//   sample_valid         one-cycle pulse when audio_sample updates
//   word_addr            address of the word currently being played
//
// State        | meaning
// S_FETCH      | read request held until flash_waitrequest drops
// S_WAIT_DATA  | request accepted, waiting for flash_readdatavalid
// S_PLAY_FIRST | word buffered, first half goes out on the next tick
// S_PLAY_SECOND| second half goes out on the next tick, then advance address
module flash_sample_fetcher #(
  parameter int                    FREQ_DIV_WIDTH = 32,
  parameter int                    ADDR_WIDTH     = 23,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR       = 23'h7FFFF,
  parameter int                    MIN_DIV        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FREQ_DIV_WIDTH-1:0] sample_freq_div,
  input  logic                      pause,
  input  logic                      forward,
  input  logic                      fetcher_reset,
  output logic                      flash_read,
  input  logic                      flash_waitrequest,
  output logic [ADDR_WIDTH-1:0]     flash_address,
  output logic [3:0]                flash_byteenable,
  input  logic [31:0]               flash_readdata,
  input  logic                      flash_readdatavalid,
  output logic [15:0]               audio_sample,
  output logic                      sample_valid,
  output logic [ADDR_WIDTH-1:0]     word_addr
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT_DATA,
    S_PLAY_FIRST,
    S_PLAY_SECOND
  } state_t;

  state_t                    r_state;
  logic [FREQ_DIV_WIDTH-1:0] r_cnt;
  logic                      r_restart_pending;
  logic [31:0]               r_word;
  logic                      r_flash_read;
  logic [ADDR_WIDTH-1:0]     r_flash_address;
  logic [ADDR_WIDTH-1:0]     r_word_addr;
  logic [15:0]               r_audio_sample;
  logic                      r_sample_valid;

  logic [FREQ_DIV_WIDTH-1:0] w_eff_div;
  logic                      w_tick;
  logic                      w_accept;
  logic                      w_restart_now;
  logic [ADDR_WIDTH-1:0]     w_restart_addr;
  logic [ADDR_WIDTH-1:0]     w_next_addr;
  logic [15:0]               w_first_half;
  logic [15:0]               w_second_half;

  assign w_eff_div = (sample_freq_div < FREQ_DIV_WIDTH'(MIN_DIV)) ?
                     FREQ_DIV_WIDTH'(MIN_DIV) : sample_freq_div;

  // >= rather than == so a divisor shrinking below the current count still
  // produces a tick right away instead of wrapping the counter.
  assign w_tick = !pause && (r_cnt >= (w_eff_div - FREQ_DIV_WIDTH'(1)));

  assign w_accept = (r_state == S_FETCH) && r_flash_read && !flash_waitrequest;

  // A restart takes effect immediately unless a read is in flight; an
  // in-flight read is allowed to complete and its data is dropped.
  assign w_restart_now =
    (fetcher_reset && (((r_state == S_FETCH) && !w_accept) ||
                       (r_state == S_PLAY_FIRST) || (r_state == S_PLAY_SECOND))) ||
    ((r_state == S_WAIT_DATA) && flash_readdatavalid &&
     (r_restart_pending || fetcher_reset));

  assign w_restart_addr = forward ? '0 : MAX_ADDR;

  always_comb begin
    w_next_addr = r_word_addr;
    if (forward) begin
      w_next_addr = (r_word_addr == MAX_ADDR) ? '0 : r_word_addr + ADDR_WIDTH'(1);
    end else begin
      w_next_addr = (r_word_addr == '0) ? MAX_ADDR : r_word_addr - ADDR_WIDTH'(1);
    end
  end

  // Direction is looked at on each half-select independently.
  assign w_first_half  = forward ? r_word[15:0]  : r_word[31:16];
  assign w_second_half = forward ? r_word[31:16] : r_word[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_restart_now) begin
      r_cnt <= '0;
    end else if (pause) begin
      r_cnt <= r_cnt;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + FREQ_DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_FETCH;
      r_restart_pending <= 1'b0;
      r_word            <= '0;
      r_flash_read      <= 1'b0;
      r_flash_address   <= '0;
      r_word_addr       <= '0;
      r_audio_sample    <= '0;
      r_sample_valid    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if ((r_state == S_WAIT_DATA) && flash_readdatavalid) begin
        r_word <= flash_readdata;
      end
      if (w_restart_now) begin
        r_word_addr       <= w_restart_addr;
        r_flash_address   <= w_restart_addr;
        r_flash_read      <= 1'b1;
        r_restart_pending <= 1'b0;
        r_state           <= S_FETCH;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (!r_flash_read) begin
              // only reached straight out of reset
              r_flash_read    <= 1'b1;
              r_flash_address <= r_word_addr;
            end else if (!flash_waitrequest) begin
              r_flash_read <= 1'b0;
              r_state      <= S_WAIT_DATA;
              if (fetcher_reset) begin
                r_restart_pending <= 1'b1;
              end
            end
          end
          S_WAIT_DATA: begin
            if (fetcher_reset) begin
              r_restart_pending <= 1'b1;
            end
            if (flash_readdatavalid) begin
              r_state <= S_PLAY_FIRST;
            end
          end
          S_PLAY_FIRST: begin
            if (w_tick) begin
              r_audio_sample <= w_first_half;
              r_sample_valid <= 1'b1;
              r_state        <= S_PLAY_SECOND;
            end
          end
          S_PLAY_SECOND: begin
            if (w_tick) begin
              r_audio_sample  <= w_second_half;
              r_sample_valid  <= 1'b1;
              r_word_addr     <= w_next_addr;
              r_flash_address <= w_next_addr;
              r_flash_read    <= 1'b1;
              r_state         <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign flash_read       = r_flash_read;
  assign flash_address    = r_flash_address;
  assign flash_byteenable = 4'hF;
  assign audio_sample     = r_audio_sample;
  assign sample_valid     = r_sample_valid;
  assign word_addr        = r_word_addr;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Testbench for flash_sample_fetcher: table of playback scenarios plus
// hand-written sequences for pause, restart during a read and reset.
module tb_flash_sample_fetcher;

  localparam int          STALL = 2;
  localparam int          LAT   = 3;
  localparam logic [22:0] MAXA  = 23'h7FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] sample_freq_div;
  logic        pause;
  logic        forward;
  logic        fetcher_reset;
  logic        flash_read;
  logic        flash_waitrequest;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic [22:0] word_addr;

  flash_sample_fetcher dut (
    .clk                 (clk),
    .rst                 (rst),
    .sample_freq_div     (sample_freq_div),
    .pause               (pause),
    .forward             (forward),
    .fetcher_reset       (fetcher_reset),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_address       (flash_address),
    .flash_byteenable    (flash_byteenable),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid),
    .word_addr           (word_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- flash model ----------------
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'hA5A5};
  endfunction

  bit          m_acc;
  bit          m_rst;
  logic [22:0] m_addr;
  logic [22:0] m_pend;
  int          m_rdv_cnt;
  int          m_stall;

  initial begin
    flash_waitrequest   = 1'b0;
    flash_readdata      = 32'h0;
    flash_readdatavalid = 1'b0;
    m_rdv_cnt           = 0;
    m_stall             = STALL;
    m_pend              = '0;
  end

  always @(posedge clk) begin
    m_acc  = flash_read && !flash_waitrequest && !rst;
    m_addr = flash_address;
    m_rst  = rst;
    #1;
    flash_readdatavalid = 1'b0;
    if (m_rst) begin
      m_rdv_cnt = 0;
      m_stall   = STALL;
    end else begin
      if (m_rdv_cnt > 0) begin
        m_rdv_cnt--;
        if (m_rdv_cnt == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata      = mem_word(m_pend);
        end
      end
      if (m_acc) begin
        m_pend    = m_addr;
        m_rdv_cnt = LAT;
        m_stall   = STALL;
      end
    end
    if (flash_read && m_stall > 0) begin
      flash_waitrequest = 1'b1;
      m_stall--;
    end else begin
      flash_waitrequest = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input int max, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          mode;   // 0 = rst, 1 = restart forward, 2 = restart backward
    bit          fwd;
    logic [31:0] div;
    logic [31:0] word;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [22:0] nxt;
    int          gap;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int  cyc;
    bit  ok;
    bit  got_pulse;
    bit  changed;
    bit  saw_rdv;
    bit  early_read;
    logic [15:0] a0;
    logic [22:0] start_a;

    tbl[0] = '{0, 1'b1, 32'd4, 32'hAAAA5555, 16'h5555, 16'hAAAA, 23'h1,     4};
    tbl[1] = '{0, 1'b0, 32'd4, 32'h12345678, 16'h1234, 16'h5678, MAXA,      4};
    tbl[2] = '{2, 1'b1, 32'd4, 32'hCAFEBEEF, 16'hBEEF, 16'hCAFE, 23'h0,     4};
    tbl[3] = '{1, 1'b1, 32'd0, 32'h80007FFF, 16'h7FFF, 16'h8000, 23'h1,     2};
    tbl[4] = '{2, 1'b0, 32'd7, 32'hCAFEBEEF, 16'hCAFE, 16'hBEEF, 23'h7FFFE, 7};

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    sample_freq_div = 32'd4;
    pause = 1'b0;
    forward = 1'b1;
    fetcher_reset = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_flash_read",    32'(flash_read),    32'h0);
    check("rst_flash_address", 32'(flash_address), 32'h0);
    check("rst_audio_sample",  32'(audio_sample),  32'h0);
    check("rst_sample_valid",  32'(sample_valid),  32'h0);
    check("rst_word_addr",     32'(word_addr),     32'h0);
    check("byteenable",        32'(flash_byteenable), 32'hF);

    // ---------------- table-driven scenarios ----------------
    for (int i = 0; i < 5; i++) begin
      sample_freq_div = tbl[i].div;
      start_a = (tbl[i].mode == 2) ? MAXA : 23'h0;
      mem[int'(start_a)] = tbl[i].word;
      if (tbl[i].mode == 0) begin
        forward = tbl[i].fwd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end else begin
        forward = (tbl[i].mode == 1);
        fetcher_reset = 1'b1;
        @(negedge clk);
        fetcher_reset = 1'b0;
        forward = tbl[i].fwd;
      end
      wait_pulse(200, cyc, ok);
      check($sformatf("v%0d_first_pulse_seen", i), 32'(ok), 32'h1);
      check($sformatf("v%0d_sample1", i), 32'(audio_sample), 32'(tbl[i].s1));
      wait_pulse(50, cyc, ok);
      check($sformatf("v%0d_gap", i), 32'(cyc), 32'(tbl[i].gap));
      check($sformatf("v%0d_sample2", i), 32'(audio_sample), 32'(tbl[i].s2));
      check($sformatf("v%0d_next_addr", i), 32'(flash_address), 32'(tbl[i].nxt));
      check($sformatf("v%0d_next_read", i), 32'(flash_read), 32'h1);
    end

    // ---------------- pause mid-word ----------------
    sample_freq_div = 32'd4;
    mem[0] = 32'h13572468;
    forward = 1'b1;
    fetcher_reset = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b0;
    wait_pulse(200, cyc, ok);
    check("pause_first_seen", 32'(ok), 32'h1);
    check("pause_sample1", 32'(audio_sample), 32'h2468);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    a0 = audio_sample;
    got_pulse = 1'b0;
    changed = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sample_valid) got_pulse = 1'b1;
      if (audio_sample !== a0 || word_addr !== 23'h0) changed = 1'b1;
    end
    check("pause_no_pulse", 32'(got_pulse), 32'h0);
    check("pause_frozen", 32'(changed), 32'h0);
    pause = 1'b0;
    wait_pulse(50, cyc, ok);
    check("pause_resume_cycles", 32'(cyc), 32'd2);
    check("pause_sample2", 32'(audio_sample), 32'h1357);

    // ---------------- restart while a read is in flight ----------------
    sample_freq_div = 32'd2;
    ok = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (flash_read && flash_address == 23'h100) begin
        ok = 1'b1;
        break;
      end
    end
    check("wd_reach_0x100", 32'(ok), 32'h1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!flash_read) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wd_accepted", 32'(ok), 32'h1);
    check("wd_word_addr", 32'(word_addr), 32'h100);
    fetcher_reset = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b1;  // second request while one is pending
    saw_rdv = flash_readdatavalid;
    early_read = flash_read;
    got_pulse = sample_valid;
    @(negedge clk);
    fetcher_reset = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (sample_valid) got_pulse = 1'b1;
      if (flash_read) begin
        if (!saw_rdv) early_read = 1'b1;
        ok = 1'b1;
        break;
      end
      if (flash_readdatavalid) saw_rdv = 1'b1;
      @(negedge clk);
    end
    check("wd_read_reissued", 32'(ok), 32'h1);
    check("wd_read_before_rdv", 32'(early_read), 32'h0);
    check("wd_no_pulse", 32'(got_pulse), 32'h0);
    check("wd_restart_addr", 32'(flash_address), 32'h0);
    check("wd_restart_word_addr", 32'(word_addr), 32'h0);
    // single restart only: word 0 plays and address 1 follows
    wait_pulse(100, cyc, ok);
    check("wd_after_sample1", 32'(audio_sample), 32'h2468);

    // ---------------- reset in the middle of a fetch ----------------
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (flash_read && flash_address == 23'h1) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst_reach_fetch", 32'(ok), 32'h1);
    check("midrst_audio_nonzero", 32'(audio_sample != 16'h0), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flash_read",    32'(flash_read),    32'h0);
    check("midrst_flash_address", 32'(flash_address), 32'h0);
    check("midrst_audio_sample",  32'(audio_sample),  32'h0);
    check("midrst_sample_valid",  32'(sample_valid),  32'h0);
    check("midrst_word_addr",     32'(word_addr),     32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_sample_fetcher.md
Name: flash_sample_fetcher

Overview:
- Downstream consumer of the playback controller's pause/forward/fetcher_reset/sample_freq_div outputs.
- Reads 32-bit words from on-board flash over an Avalon-MM read master and splits each word into two 16-bit audio samples.
- Presents one sample per sample period to the audio codec interface.
- Handles pause, forward/backward playback, restart and address wrap-around.

Parameters:
- FREQ_DIV_WIDTH, 32, width of sample_freq_div.
- ADDR_WIDTH, 23, flash word-address width.
- MAX_ADDR, 23'h7FFFF, last word address of the song; playback wraps between 0 and MAX_ADDR.
- MIN_DIV, 2, minimum effective divisor; smaller sample_freq_div values are clamped to this.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- sample_freq_div, in, FREQ_DIV_WIDTH, clk cycles per sample period.
- pause, in, 1, 1 = hold playback.
- forward, in, 1, 1 = ascending addresses, 0 = descending.
- fetcher_reset, in, 1, single-cycle restart request.
- flash_read, out, 1, Avalon read request.
- flash_waitrequest, in, 1, Avalon stall.
- flash_address, out, ADDR_WIDTH, word address.
- flash_byteenable, out, 4, constant 4'hF.
- flash_readdata, in, 32, read data.
- flash_readdatavalid, in, 1, read data qualifier.
- audio_sample, out, 16, current sample (two's complement).
- sample_valid, out, 1, one-cycle pulse when audio_sample updates.
- word_addr, out, ADDR_WIDTH, address of the word currently being played (for display).

Behaviour:
- Reset (rst high at a clk edge) sets the following; reset has priority over every other input:
  - flash_read=0, flash_address=0, audio_sample=0, sample_valid=0, word_addr=0.
  - Tick counter=0, state=FETCH, restart_pending=0.
- Tick generator:
  - eff_div = max(sample_freq_div, MIN_DIV).
  - Counter increments every clk while pause=0.
  - When counter >= eff_div-1: tick=1 for one cycle and counter returns to 0.
  - With pause=1 the counter holds and no tick is produced.
  - Divisor changes apply immediately; if the counter already exceeds the new eff_div-1, the tick fires on the next cycle.
- FSM states: FETCH, WAIT_DATA, PLAY_FIRST, PLAY_SECOND.
  - FETCH: flash_read=1, flash_address=word_addr.
    - Hold flash_read while flash_waitrequest=1.
    - The cycle with flash_waitrequest=0 accepts the request: next state WAIT_DATA, flash_read=0.
  - WAIT_DATA: on flash_readdatavalid, latch flash_readdata into the word buffer.
    - If restart_pending=1, discard the data, apply the restart, go to FETCH.
    - Otherwise go to PLAY_FIRST.
  - PLAY_FIRST: on tick, audio_sample = readdata[15:0] if forward else readdata[31:16]; sample_valid=1 next cycle; go to PLAY_SECOND.
  - PLAY_SECOND: on tick, output the other half; sample_valid=1; advance word_addr; go to FETCH.
    - forward=1: MAX_ADDR wraps to 0, otherwise +1.
    - forward=0: 0 wraps to MAX_ADDR, otherwise -1.
  - Direction is sampled separately at each half-select and at each address advance. A mid-word direction change therefore affects the next sample/advance only.
- fetcher_reset:
  - In FETCH, PLAY_FIRST or PLAY_SECOND: next cycle word_addr = 0 if forward else MAX_ADDR, state=FETCH, tick counter cleared. audio_sample holds and no sample_valid pulse.
  - In FETCH after the request is accepted, or in WAIT_DATA: an issued read is never aborted. Set restart_pending and apply the restart when readdatavalid arrives.
  - A second fetcher_reset while restart_pending=1 is absorbed.
- Pause: FSM may still complete a pending flash read and reach PLAY_FIRST. No ticks occur, so audio_sample and word_addr freeze. Resume continues from the held counter value.
- sample_valid is never asserted in a cycle without a preceding tick; at most one pulse per tick.
- Latency: tick to audio_sample/sample_valid = 1 clk.

Test Plan:
- Forward play, div=4, flash model returns word 32'hAAAA5555 at addr 0 with waitrequest=1 for 2 cycles, then readdatavalid 3 cycles later:
  - audio_sample=5555 then AAAA, each with a sample_valid pulse 4 clk apart.
  - flash_address then becomes 1.
- Backward from word_addr=0, div=4, readdata 32'h12345678:
  - First sample 1234, second 5678.
  - flash_address then becomes 23'h7FFFF (wrap).
- Forward at MAX_ADDR: after both samples, next flash_address=0.
- pause=1 held 50 cycles mid-word: no sample_valid pulses, audio_sample frozen. pause=0: next pulse arrives after the remaining counter cycles.
- fetcher_reset during WAIT_DATA at word_addr=0x100, forward=1:
  - flash_read stays 0 until readdatavalid.
  - No sample_valid pulse.
  - Next flash request is at address 0.
- sample_freq_div=0: ticks occur every 2 clk (MIN_DIV clamp). rst asserted mid-FETCH: all outputs 0 next cycle.
